// File: rtl/counter_monitor.sv
// Passive scoreboard for an up/down triangle counter: rebuilds the expected count from the
// previous cycle's inputs, flags bad steps, and reports turnarounds, direction and lock.
module counter_monitor #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned LOCK_N = 4
) (
    input  logic             clk,
    input  logic             syn_rst,
    input  logic             enb,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] count,
    output logic             dir_up,
    output logic             peak,
    output logic             trough,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             locked
);

    localparam int unsigned GW = $clog2(LOCK_N + 1);
    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [WIDTH-1:0] MAX_M1 = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO   = '0;
    localparam logic [GW-1:0]    LOCK_V = GW'(LOCK_N);

    typedef enum logic {StSync, StTrack} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_count_q, prev_data_q;
    logic             prev_enb_q, prev_load_q, prev_dir_q;
    logic             dir_q, dir_d;
    logic             peak_q, peak_d, trough_q, trough_d;
    logic             step_err_q, step_err_d, locked_q, locked_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [GW-1:0]    good_q, good_d;
    logic [WIDTH-1:0] exp_count;
    logic             mismatch;

    always_comb begin
        exp_count = prev_count_q;
        if (prev_load_q) begin
            exp_count = prev_data_q;
        end else if (prev_enb_q) begin
            // Step direction is the one in force when the previous sample was taken.
            exp_count = prev_dir_q ? prev_count_q + ONE : prev_count_q - ONE;
        end
        mismatch = (count != exp_count);
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        peak_d     = 1'b0;
        trough_d   = 1'b0;
        step_err_d = 1'b0;
        err_d      = err_q;
        good_d     = good_q;
        locked_d   = locked_q;

        if (enb && count == MAX_M1) begin
            dir_d = 1'b0;
        end else if (enb && count == ONE) begin
            dir_d = 1'b1;
        end

        unique case (state_q)
            StSync: begin
                state_d = StTrack;
            end
            StTrack: begin
                if (mismatch) begin
                    step_err_d = 1'b1;
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    good_d   = '0;
                    locked_d = 1'b0;
                end else begin
                    if (good_q != LOCK_V) begin
                        good_d = good_q + 1'b1;
                    end
                    locked_d = (good_d == LOCK_V);
                    peak_d   = prev_enb_q && !prev_load_q && prev_count_q == MAX_M1 &&
                               count == MAX;
                    trough_d = prev_enb_q && !prev_load_q && prev_count_q == ONE &&
                               count == ZERO;
                end
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state_q      <= StSync;
            prev_count_q <= '0;
            prev_data_q  <= '0;
            prev_enb_q   <= 1'b0;
            prev_load_q  <= 1'b0;
            prev_dir_q   <= 1'b1;
            dir_q        <= 1'b1;
            peak_q       <= 1'b0;
            trough_q     <= 1'b0;
            step_err_q   <= 1'b0;
            err_q        <= '0;
            good_q       <= '0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= count;
            prev_data_q  <= data_in;
            prev_enb_q   <= enb;
            prev_load_q  <= load;
            prev_dir_q   <= dir_q;
            dir_q        <= dir_d;
            peak_q       <= peak_d;
            trough_q     <= trough_d;
            step_err_q   <= step_err_d;
            err_q        <= err_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
        end
    end

    assign dir_up   = dir_q;
    assign peak     = peak_q;
    assign trough   = trough_q;
    assign step_err = step_err_q;
    assign err_cnt  = err_q;
    assign locked   = locked_q;

endmodule
